// File: rtl/mcs_brg_pkg.sv
// Shared types, constants and helpers for the MCS-to-Wishbone bridge.
package mcs_brg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } brg_state_t;

    localparam logic [31:0] BRG_MISS_DATA    = 32'h0000_0000;
    localparam logic [31:0] BRG_TIMEOUT_DATA = 32'hFFFF_FFFF;

    // Width of the slave-select field taken from the top of the word address.
    function automatic int unsigned slave_bits(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/mcs_brg_timer.sv
// Bus-cycle wait counter and saturating count of aborted (timed-out) cycles.
module mcs_brg_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_start,
    input  logic       bus_active,
    input  logic       ack,
    output logic       expired,
    output logic [7:0] timeout_cnt
);

    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset || bus_start) begin
            wait_cnt <= '0;
        end else if (bus_active) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Expires during the TIMEOUT_CYCLES-th cycle spent in BUS.
    assign expired = bus_active && (({1'b0, wait_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else if (expired && !ack && (timeout_cnt != 8'hFF)) begin
            timeout_cnt <= timeout_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mcs_wb_bridge_n.sv
// MCS I/O bus to N-slave Wishbone classic bridge with miss completion.
// Define MCS_BRG_TIMEOUT_EN to build the bus-timeout abort and timeout_cnt.
module mcs_wb_bridge_n
    import mcs_brg_pkg::*;
#(
    parameter logic [31:0] BRG_BASE       = 32'hc000_0000,
    parameter int unsigned N_SLAVES       = 2,
    parameter int unsigned ADDR_WIDTH     = 22,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     io_addr_strobe,
    input  logic                     io_read_strobe,
    input  logic                     io_write_strobe,
    input  logic [3:0]               io_byte_enable,
    input  logic [31:0]              io_address,
    input  logic [31:0]              io_write_data,
    output logic [31:0]              io_read_data,
    output logic                     io_ready,
    output logic [N_SLAVES-1:0]      CYC_O,
    output logic                     STB_O,
    output logic                     WE_O,
    output logic [3:0]               SEL_O,
    output logic [ADDR_WIDTH-1:0]    ADDR_O,
    output logic [31:0]              DAT_O,
    input  logic [32*N_SLAVES-1:0]   DAT_I,
    input  logic [N_SLAVES-1:0]      ACK_I,
    output logic [7:0]               timeout_cnt
);

    localparam int unsigned SB = slave_bits(N_SLAVES);

    if (N_SLAVES == 0 || N_SLAVES > 8) begin : g_bad_n_slaves
        $error("mcs_wb_bridge_n: N_SLAVES must be 1..8");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mcs_wb_bridge_n: TIMEOUT_CYCLES must be 1..65535");
    end

    brg_state_t            state, state_n;
    logic                  miss_wait, miss_wait_n;
    logic [SB-1:0]         si, si_n, req_si;
    logic                  ready_n;
    logic [31:0]           rdata_n;
    logic [N_SLAVES-1:0]   cyc_n, req_onehot;
    logic                  stb_n, we_n;
    logic [3:0]            sel_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [31:0]           dat_n;
    logic                  req, win_hit, mapped, ack_sel, expired;
    logic [31:0]           rd_sel;
    logic                  unused_bits;

    assign req         = io_read_strobe | io_write_strobe;
    assign win_hit     = (io_address[31:24] == BRG_BASE[31:24]);
    assign req_si      = io_address[ADDR_WIDTH+1 -: SB];
    assign mapped      = ({{(32-SB){1'b0}}, req_si} < N_SLAVES);
    assign unused_bits = ^{io_addr_strobe, io_address[1:0]};

    always_comb begin
        ack_sel    = 1'b0;
        rd_sel     = '0;
        req_onehot = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (si == SB'(k)) begin
                ack_sel = ACK_I[k];
                rd_sel  = DAT_I[32*k +: 32];
            end
            req_onehot[k] = (req_si == SB'(k));
        end
    end

`ifdef MCS_BRG_TIMEOUT_EN
    mcs_brg_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .bus_start  (state == IDLE && state_n == BUS),
        .bus_active (state == BUS),
        .ack        (ack_sel),
        .expired    (expired),
        .timeout_cnt(timeout_cnt)
    );
`else
    assign expired     = 1'b0;
    assign timeout_cnt = '0;
`endif

    // Misses spend an extra DONE cycle (miss_wait) so that their io_ready
    // lands in cycle 2, matching a zero-wait slave.
    always_comb begin
        state_n     = state;
        miss_wait_n = miss_wait;
        si_n        = si;
        ready_n     = 1'b0;
        rdata_n     = io_read_data;
        cyc_n       = CYC_O;
        stb_n       = STB_O;
        we_n        = WE_O;
        sel_n       = SEL_O;
        addr_n      = ADDR_O;
        dat_n       = DAT_O;
        unique case (state)
            IDLE: begin
                if (req) begin
                    addr_n = io_address[ADDR_WIDTH+1:2];
                    dat_n  = io_write_data;
                    sel_n  = io_byte_enable;
                    we_n   = io_write_strobe;
                    si_n   = req_si;
                    if (win_hit && mapped) begin
                        cyc_n   = req_onehot;
                        stb_n   = 1'b1;
                        state_n = BUS;
                    end else begin
                        rdata_n     = BRG_MISS_DATA;
                        miss_wait_n = 1'b1;
                        state_n     = DONE;
                    end
                end
            end
            BUS: begin
                if (ack_sel) begin
                    if (!WE_O) rdata_n = rd_sel;
                    cyc_n   = '0;
                    stb_n   = 1'b0;
                    ready_n = 1'b1;
                    state_n = DONE;
                end else if (expired) begin
                    rdata_n = BRG_TIMEOUT_DATA;
                    cyc_n   = '0;
                    stb_n   = 1'b0;
                    ready_n = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: begin
                if (miss_wait) begin
                    miss_wait_n = 1'b0;
                    ready_n     = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            miss_wait    <= 1'b0;
            si           <= '0;
            io_ready     <= 1'b0;
            io_read_data <= '0;
            CYC_O        <= '0;
            STB_O        <= 1'b0;
            WE_O         <= 1'b0;
            SEL_O        <= '0;
            ADDR_O       <= '0;
            DAT_O        <= '0;
        end else begin
            state        <= state_n;
            miss_wait    <= miss_wait_n;
            si           <= si_n;
            io_ready     <= ready_n;
            io_read_data <= rdata_n;
            CYC_O        <= cyc_n;
            STB_O        <= stb_n;
            WE_O         <= we_n;
            SEL_O        <= sel_n;
            ADDR_O       <= addr_n;
            DAT_O        <= dat_n;
        end
    end

endmodule

// File: tb/tb_mcs_wb_bridge_n.sv
// Directed, table-driven bench for mcs_wb_bridge_n (two slaves, 22-bit address).
// Timeout sequences build only when MCS_BRG_TIMEOUT_EN is defined.
module tb_mcs_wb_bridge_n;

    localparam int unsigned NS  = 2;
    localparam int unsigned AW  = 22;
    localparam int unsigned TMO = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]          io_byte_enable;
    logic [31:0]         io_address, io_write_data, io_read_data;
    logic                io_ready;
    logic [NS-1:0]       CYC_O;
    logic                STB_O, WE_O;
    logic [3:0]          SEL_O;
    logic [AW-1:0]       ADDR_O;
    logic [31:0]         DAT_O;
    logic [32*NS-1:0]    DAT_I;
    logic [NS-1:0]       ACK_I;
    logic [7:0]          timeout_cnt;

    always #5 clk = ~clk;

    mcs_wb_bridge_n #(
        .BRG_BASE      (32'hc000_0000),
        .N_SLAVES      (NS),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .io_addr_strobe (io_addr_strobe),
        .io_read_strobe (io_read_strobe),
        .io_write_strobe(io_write_strobe),
        .io_byte_enable (io_byte_enable),
        .io_address     (io_address),
        .io_write_data  (io_write_data),
        .io_read_data   (io_read_data),
        .io_ready       (io_ready),
        .CYC_O          (CYC_O),
        .STB_O          (STB_O),
        .WE_O           (WE_O),
        .SEL_O          (SEL_O),
        .ADDR_O         (ADDR_O),
        .DAT_O          (DAT_O),
        .DAT_I          (DAT_I),
        .ACK_I          (ACK_I),
        .timeout_cnt    (timeout_cnt)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        int            ack_dly;   // ACK in cycle 1+ack_dly of the bus cycle
        logic          spur;      // pulse the non-selected slave's ACK
        logic          poke;      // fire a strobe while in BUS
        logic [31:0]   d0;
        logic [31:0]   d1;
        logic [NS-1:0] exp_cyc;
        logic [AW-1:0] exp_addr;
        logic          exp_we;
        logic [3:0]    exp_sel;
        logic [31:0]   exp_dat;
        int            exp_rdy;
        logic [31:0]   exp_rdata;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          r_rdy, r_hold_err, r_stb_err;
    logic [31:0] r_rdata;
    logic [NS-1:0] r_cyc;
    logic [2:0]  r_pre;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int bus_n;
        @(posedge clk); #1;
        r_pre           = {io_ready, |CYC_O, STB_O};
        io_addr_strobe  = 1'b1;
        io_read_strobe  = v.rd;
        io_write_strobe = v.wr;
        io_address      = v.addr;
        io_write_data   = v.wdata;
        io_byte_enable  = v.be;
        DAT_I           = {v.d1, v.d0};
        r_rdy = -1; r_cyc = '0; r_hold_err = 0; r_stb_err = 0; bus_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            io_addr_strobe  = 1'b0;
            io_read_strobe  = 1'b0;
            io_write_strobe = 1'b0;
            ACK_I           = '0;
            if (v.poke && n == 2) begin
                io_addr_strobe  = 1'b1;
                io_write_strobe = 1'b1;
                io_address      = 32'hC080_0040;
                io_write_data   = 32'h9999_9999;
                io_byte_enable  = 4'h1;
            end
            if (STB_O !== (|CYC_O)) r_stb_err++;
            if (io_ready) begin
                r_rdy   = n;
                r_rdata = io_read_data;
                if (CYC_O != '0) r_stb_err++;
                break;
            end
            r_cyc |= CYC_O;
            if (CYC_O != '0) begin
                if (ADDR_O !== v.exp_addr || WE_O !== v.exp_we ||
                    SEL_O !== v.exp_sel || DAT_O !== v.exp_dat) r_hold_err++;
                if (bus_n == v.ack_dly) ACK_I = v.exp_cyc & CYC_O;
                if (v.spur) ACK_I = ACK_I | (~v.exp_cyc & {NS{n[0]}});
                bus_n++;
            end
        end
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        ACK_I = '0;
    endtask

    vec_t vecs [8];
    vec_t vt;
    int   quiet_err;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //       rd    wr    addr          wdata         be     dly spur  poke  d0            d1            cyc    addr      we    sel    dat           rdy rdata
        vecs[0] = '{1'b1, 1'b0, 32'hC000_0010, 32'h0,        4'hF,  0, 1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 2'b01, 22'h000004, 1'b0, 4'hF,  32'h0,        2, 32'h1234_5678};
        vecs[1] = '{1'b0, 1'b1, 32'hC080_0008, 32'hA5A5_A5A5, 4'h3,  3, 1'b0, 1'b0, 32'h1111_1111, 32'h2222_2222, 2'b10, 22'h200002, 1'b1, 4'h3,  32'hA5A5_A5A5, 5, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        4'hF,  0, 1'b0, 1'b0, 32'h3333_3333, 32'h4444_4444, 2'b00, 22'h000000, 1'b0, 4'hF,  32'h0,        2, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'hC080_0100, 32'h0,        4'hF,  5, 1'b1, 1'b0, 32'h1111_1111, 32'hCAFE_F00D, 2'b10, 22'h200040, 1'b0, 4'hF,  32'h0,        7, 32'hCAFE_F00D};
        vecs[4] = '{1'b0, 1'b1, 32'h4000_0004, 32'h7654_3210, 4'hF,  0, 1'b0, 1'b0, 32'h5555_5555, 32'h6666_6666, 2'b00, 22'h000000, 1'b1, 4'hF,  32'h7654_3210, 2, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 32'hC000_0020, 32'h0BAD_F00D, 4'hC,  1, 1'b0, 1'b0, 32'h7777_7777, 32'h8888_8888, 2'b01, 22'h000008, 1'b1, 4'hC,  32'h0BAD_F00D, 3, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'hC03F_FFFC, 32'h0,        4'hF,  2, 1'b0, 1'b1, 32'h5555_AAAA, 32'hAAAA_5555, 2'b01, 22'h0FFFFF, 1'b0, 4'hF,  32'h0,        4, 32'h5555_AAAA};
        vecs[7] = '{1'b1, 1'b0, 32'hC0FF_FFFC, 32'h0,        4'hF,  0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 22'h3FFFFF, 1'b0, 4'hF,  32'h0,        2, 32'h0F0F_0F0F};

        reset = 1'b1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_write_strobe = 1'b0;
        io_byte_enable = '0; io_address = '0; io_write_data = '0;
        DAT_I = '0; ACK_I = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst.io_ready", 32'(io_ready), 32'h0);
        check("rst.io_read_data", io_read_data, 32'h0);
        check("rst.cyc_stb_we", {29'h0, |CYC_O, STB_O, WE_O}, 32'h0);
        check("rst.sel_addr", {6'h0, SEL_O, ADDR_O}, 32'h0);
        check("rst.dat_o", DAT_O, 32'h0);
        check("rst.timeout_cnt", 32'(timeout_cnt), 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
            check($sformatf("v%0d.idle_before", i), 32'(r_pre), 32'h0);
            check($sformatf("v%0d.cyc", i), 32'(r_cyc), 32'(vecs[i].exp_cyc));
            check($sformatf("v%0d.ready_cycle", i), 32'(r_rdy), 32'(vecs[i].exp_rdy));
            check($sformatf("v%0d.read_data", i), r_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d.bus_hold", i), 32'(r_hold_err), 32'h0);
            check($sformatf("v%0d.stb_cyc", i), 32'(r_stb_err), 32'h0);
        end

        // Ready pulse must not repeat and the poked strobe must not start a cycle.
        quiet_err = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (io_ready || CYC_O != '0) quiet_err++;
        end
        check("post.quiet", 32'(quiet_err), 32'h0);

        // Reset asserted while a slave is stalled in BUS.
        @(posedge clk); #1;
        io_read_strobe = 1'b1; io_address = 32'hC080_0000; io_byte_enable = 4'hF;
        @(posedge clk); #1;
        io_read_strobe = 1'b0;
        check("rstbus.cyc_up", 32'(CYC_O), 32'h2);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstbus.cyc_stb_drop", {30'h0, |CYC_O, STB_O}, 32'h0);
        check("rstbus.no_ready", 32'(io_ready), 32'h0);
        quiet_err = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (io_ready || CYC_O != '0) quiet_err++;
        end
        check("rstbus.quiet", 32'(quiet_err), 32'h0);
        run_txn(vecs[0]);
        check("rstbus.next_ready", 32'(r_rdy), 32'd2);
        check("rstbus.next_data", r_rdata, 32'h1234_5678);

`ifdef MCS_BRG_TIMEOUT_EN
        vt = '{1'b1, 1'b0, 32'hC080_0000, 32'h0, 4'hF, 1000, 1'b0, 1'b0, 32'h1, 32'h7777_7777,
               2'b10, 22'h200000, 1'b0, 4'hF, 32'h0, 11, 32'hFFFF_FFFF};
        run_txn(vt);
        check("tmo.ready_cycle", 32'(r_rdy), 32'd11);
        check("tmo.read_data", r_rdata, 32'hFFFF_FFFF);
        check("tmo.count1", 32'(timeout_cnt), 32'd1);

        // ACK in the expiry cycle completes normally.
        vt.ack_dly = 9;
        vt.exp_rdata = 32'h7777_7777;
        run_txn(vt);
        check("tmo_ack.ready_cycle", 32'(r_rdy), 32'd11);
        check("tmo_ack.read_data", r_rdata, 32'h7777_7777);
        check("tmo_ack.count", 32'(timeout_cnt), 32'd1);

        vt.ack_dly = 1000;
        for (int i = 0; i < 299; i++) run_txn(vt);
        check("tmo.saturate", 32'(timeout_cnt), 32'd255);
        check("tmo.last_data", r_rdata, 32'hFFFF_FFFF);
`else
        check("notmo.count", 32'(timeout_cnt), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcs_wb_bridge_n.md
Name: mcs_wb_bridge_n

Overview:
- Parametrised successor to the single-slave MCS I/O bridge: converts MicroBlaze MCS I/O bus strobes into registered Wishbone classic cycles.
- Fans out to N_SLAVES Wishbone slaves through per-slave CYC select.
- Adds byte-lane select, bridge-miss completion and an optional bus timeout, so a dead or absent slave cannot hang the CPU.
- Sits between the cpu instance and the MMIO/video subsystems in the top level.

Parameters:
- BRG_BASE, 32'hc000_0000: bridge window base; io_address[31:24] must equal BRG_BASE[31:24].
- N_SLAVES, 2: number of Wishbone slave ports, 1..8.
- ADDR_WIDTH, 22: Wishbone word-address width, taken from io_address[ADDR_WIDTH+1:2].
- TIMEOUT_CYCLES, 255: cycles without ACK before the bridge aborts (used only with the optional feature); 1..65535.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- io_addr_strobe  in  1  MCS address strobe.
- io_read_strobe  in  1  MCS read request.
- io_write_strobe  in  1  MCS write request.
- io_byte_enable  in  4  MCS byte lanes.
- io_address  in  32  MCS byte address.
- io_write_data  in  32  MCS write data.
- io_read_data  out  32  registered read data to the MCS.
- io_ready  out  1  one-cycle completion pulse to the MCS.
- CYC_O  out  N_SLAVES  one-hot Wishbone cycle, one bit per slave.
- STB_O  out  1  Wishbone strobe.
- WE_O  out  1  Wishbone write enable.
- SEL_O  out  4  Wishbone byte select.
- ADDR_O  out  ADDR_WIDTH  Wishbone word address.
- DAT_O  out  32  Wishbone write data.
- DAT_I  in  32*N_SLAVES  flattened slave read data; slave k occupies bits [32k+31:32k].
- ACK_I  in  N_SLAVES  per-slave acknowledge.
- timeout_cnt  out  8  saturating count of timed-out cycles.

Behaviour:
- Slave index: SI = ADDR_O[ADDR_WIDTH-1 -: SB], where SB = max(1, clog2(N_SLAVES)). If SI >= N_SLAVES the access is an unmapped hit.
- Reset values: every output is 0 and the FSM is IDLE. Reset asserted mid-transaction drops CYC_O/STB_O on the next edge; the pending transfer is discarded and io_ready is not pulsed.
- FSM: IDLE, BUS, DONE.
- IDLE: on io_read_strobe or io_write_strobe:
  - Register io_address, io_write_data and io_byte_enable, plus WE = io_write_strobe.
  - Window hit with SI < N_SLAVES: go to BUS.
  - Window miss, or unmapped hit: go to DONE with read data 0x0000_0000; writes are dropped.
- Simultaneous read and write strobes are treated as a write.
- Strobes in BUS or DONE are ignored.
- BUS: CYC_O[SI]=1 and STB_O=1, with ADDR_O/DAT_O/SEL_O/WE_O held stable.
  - On ACK_I[SI]=1, capture DAT_I slice SI into io_read_data (reads only; unchanged on writes), drop CYC/STB and go to DONE.
  - ACK from a non-selected slave is ignored.
- DONE: io_ready=1 for exactly one cycle, then IDLE.
- Latency: strobe at cycle 0, CYC/STB from cycle 1; ACK at cycle k gives io_ready at cycle k+1.
  - Zero-wait slave (ACK in cycle 1): io_ready in cycle 2.
  - Miss: io_ready in cycle 2.
- Back-to-back: a strobe may be accepted in the cycle after DONE.

Optional Feature:
- Macro: MCS_BRG_TIMEOUT_EN.
- Defined:
  - A 16-bit wait counter clears on entry to BUS and increments each cycle in BUS.
  - When it reaches TIMEOUT_CYCLES with no valid ACK, CYC/STB drop, io_read_data = 0xFFFF_FFFF, the FSM goes to DONE and timeout_cnt increments, saturating at 255.
  - An ACK arriving in the same cycle as expiry wins.
- Undefined: no counter is built; BUS waits indefinitely and timeout_cnt is tied to 0.

Decomposition:
- Shared package mcs_brg_pkg contains:
  - the brg_state_t enum {IDLE, BUS, DONE};
  - localparams BRG_MISS_DATA = 32'h0 and BRG_TIMEOUT_DATA = 32'hFFFF_FFFF;
  - the function slave_bits(N).
- One natural sub-module, mcs_brg_timer, holds the wait counter and the saturating timeout_cnt. It is instantiated only under MCS_BRG_TIMEOUT_EN.

Test Plan:
- Read at 0xC000_0010, N_SLAVES=2, slave 0 ACKs in cycle 1 with data 0x1234_5678 -> ADDR_O=0x4, CYC_O=2'b01, io_ready in cycle 2, io_read_data=0x1234_5678.
- Write 0xA5A5_A5A5 to 0xC080_0008 with byte_enable 4'b0011 -> CYC_O=2'b10, WE_O=1, SEL_O=4'b0011, DAT_O=0xA5A5_A5A5 held until ACK_I[1]; io_ready 1 cycle after ACK.
- Read at 0x8000_0000 (window miss) -> no CYC_O ever asserted, io_ready in cycle 2, io_read_data=0.
- Slave 1 delays ACK 5 cycles while ACK_I[0] pulses spuriously -> spurious ACK ignored, io_ready exactly 6 cycles after the cycle-1 CYC assertion.
- With MCS_BRG_TIMEOUT_EN and TIMEOUT_CYCLES=10, no ACK -> CYC drops after 10 BUS cycles, io_read_data=0xFFFF_FFFF, timeout_cnt=1; after 300 such timeouts timeout_cnt stays 255.
- Assert reset during BUS -> CYC_O/STB_O=0 next edge, no io_ready, next transaction completes normally.
